// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and constants for the MEM-stage data memory
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane enables, store replication, load extraction and misalignment detect
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Low address bits are forced to alignment here; trapping is decided by the caller.
  always_comb begin
    byte_en    = 4'b1111;
    wdata_rep  = wdata;
    rdata_ext  = rword;
    misaligned = 1'b0;
    sel_byte   = rword[{addr_lo, 3'b000} +: 8];
    sel_half   = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
      end
      SZ_HALF: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{~is_unsigned & sel_half[15]}}, sel_half};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - handshaked data memory with programmable latency; DMEM_MISALIGN_TRAP_EN adds RespError
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter  int DEPTH   = 64,
  parameter  int LATENCY = 1,
  localparam int ADDR_W  = $clog2(DEPTH) + 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqUnsigned,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WriteData,
  output logic              RespValid,
  output logic [31:0]       ReadData
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic              RespError
`endif
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic               write_q, write_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               accept;
  logic               access;
  logic               suppress;

  logic [31:0]        mem [DEPTH];
  logic [31:0]        rword;
  logic [3:0]         byte_en;
  logic [31:0]        wdata_rep;
  logic [31:0]        rdata_ext;
  logic               misaligned;

  assign rword = mem[addr_q[ADDR_W-1:2]];

  dmem_lane_align u_align (
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rword       (rword),
    .byte_en     (byte_en),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext),
    .misaligned  (misaligned)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q, err_d;
  assign suppress  = misaligned;
  assign RespError = (state_q == RESP) & err_q;
`else
  logic unused_misaligned;
  assign suppress          = 1'b0;
  assign unused_misaligned = misaligned;
`endif

  // Next-state, countdown, request capture and load-result selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    size_d   = size_q;
    uns_d    = uns_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    access   = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    err_d    = err_q;
`endif
    ReqReady = (state_q != WAIT);
    accept   = ReqValid & ReqReady;
    case (state_q)
      IDLE: state_d = accept ? WAIT : IDLE;
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          access  = 1'b1;
          state_d = RESP;
          if (!write_q && !suppress) rdata_d = rdata_ext;
`ifdef DMEM_MISALIGN_TRAP_EN
          err_d = misaligned;
`endif
        end
      end
      RESP: state_d = accept ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      cnt_d   = LAT_M1;
      addr_d  = Address;
      size_d  = ReqSize;
      uns_d   = ReqUnsigned;
      write_d = ReqWrite;
      wdata_d = WriteData;
    end
  end

  // Control state and the load result register, cleared by reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
`ifdef DMEM_MISALIGN_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  // Captured request fields; only meaningful after an accept, so no reset needed.
  always_ff @(posedge Clock) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    write_q <= write_d;
    wdata_q <= wdata_d;
  end

  // Storage commits the selected lanes on the access edge; reset in WAIT aborts it.
  always_ff @(posedge Clock) begin
    if (!Reset && access && write_q && !suppress) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  assign RespValid = (state_q == RESP);
  assign ReadData  = rdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - randomized and directed checks of data_memory_ctrl at LATENCY 3 and 1
module tb_data_memory_ctrl;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst          [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_write    [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [7:0]  address      [2];
  logic [31:0] write_data   [2];
  logic        resp_valid   [2];
  logic [31:0] read_data    [2];
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        resp_error   [2];
`endif

  logic [31:0] mdl      [2][64];
  logic [31:0] rd_model [2];
  logic [31:0] rd_got;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DEPTH(64), .LATENCY(3)) u_dut3 (
    .Clock(clk), .Reset(rst[0]), .ReqValid(req_valid[0]), .ReqReady(req_ready[0]),
    .ReqWrite(req_write[0]), .ReqSize(req_size[0]), .ReqUnsigned(req_unsigned[0]),
    .Address(address[0]), .WriteData(write_data[0]), .RespValid(resp_valid[0]),
    .ReadData(read_data[0])
`ifdef DMEM_MISALIGN_TRAP_EN
    , .RespError(resp_error[0])
`endif
  );

  data_memory_ctrl #(.DEPTH(64), .LATENCY(1)) u_dut1 (
    .Clock(clk), .Reset(rst[1]), .ReqValid(req_valid[1]), .ReqReady(req_ready[1]),
    .ReqWrite(req_write[1]), .ReqSize(req_size[1]), .ReqUnsigned(req_unsigned[1]),
    .Address(address[1]), .WriteData(write_data[1]), .RespValid(resp_valid[1]),
    .ReadData(read_data[1])
`ifdef DMEM_MISALIGN_TRAP_EN
    , .RespError(resp_error[1])
`endif
  );

  function automatic int lat(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour: byte-wise little-endian memory, plain arithmetic on sizes.
  task automatic model_apply(input int d, input logic w, input logic [1:0] sz, input logic u,
                             input logic [7:0] a, input logic [31:0] wd,
                             output logic [31:0] rexp, output logic eexp);
    int nbytes, off, wi, base;
    logic [31:0] v;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    eexp   = TRAP && ((a % nbytes) != 0);
    if (!eexp) begin
      base = a - (a % nbytes);
      wi   = base / 4;
      off  = base % 4;
      if (w) begin
        for (int k = 0; k < nbytes; k++) mdl[d][wi][8*(off+k) +: 8] = wd[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < nbytes; k++) v[8*k +: 8] = mdl[d][wi][8*(off+k) +: 8];
        if (!u && v[8*nbytes-1]) begin
          for (int k = nbytes; k < 4; k++) v[8*k +: 8] = 8'hFF;
        end
        rd_model[d] = v;
      end
    end
    rexp = rd_model[d];
  endtask

  // Issue one request starting at a negedge; returns at the negedge of the response cycle.
  task automatic do_req(input int d, input logic w, input logic [1:0] sz, input logic u,
                        input logic [7:0] a, input logic [31:0] wd);
    int cyc;
    logic [31:0] rexp;
    logic eexp;
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d]    = 1'b1;
    req_write[d]    = w;
    req_size[d]     = sz;
    req_unsigned[d] = u;
    address[d]      = a;
    write_data[d]   = wd;
    @(posedge clk);
    #1;
    req_valid[d]    = 1'b0;
    req_write[d]    = 1'($urandom);
    req_size[d]     = 2'($urandom);
    address[d]      = 8'($urandom);
    write_data[d]   = $urandom;
    model_apply(d, w, sz, u, a, wd, rexp, eexp);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!resp_valid[d]) chk("req_ready_wait", 32'(req_ready[d]), 32'd0);
    end while (!resp_valid[d] && cyc < 40);
    chk("resp_latency", 32'(cyc), 32'(lat(d) + 1));
    chk("read_data", read_data[d], rexp);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("resp_error", 32'(resp_error[d]), 32'(eexp));
`endif
    rd_got = read_data[d];
  endtask

  initial begin
    logic [31:0] prev_exp, prev_rd, old30;
    logic        have_prev, e, w, u;
    logic [1:0]  sz;
    logic [7:0]  a;
    logic [31:0] wd;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0;
      req_unsigned[d] = 1'b0; address[d] = 8'd0; write_data[d] = 32'd0; rd_model[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      chk("rst_read_data", read_data[d], 32'd0);
    end

    // Give every word a known value.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) do_req(d, 1'b1, 2'd2, 1'b0, 8'(i * 4), $urandom);

    // Directed cases on the LATENCY=3 instance.
    do_req(0, 1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF);
    do_req(0, 1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
    chk("word_load", rd_got, 32'hDEADBEEF);
    do_req(0, 1'b1, 2'd0, 1'b0, 8'h13, 32'h00000080);
    do_req(0, 1'b0, 2'd0, 1'b0, 8'h13, 32'h0);
    chk("byte_signed", rd_got, 32'hFFFFFF80);
    do_req(0, 1'b0, 2'd0, 1'b1, 8'h13, 32'h0);
    chk("byte_unsigned", rd_got, 32'h00000080);
    do_req(0, 1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
    chk("byte_merge", rd_got, 32'h80ADBEEF);
    do_req(0, 1'b1, 2'd2, 1'b0, 8'h20, 32'hCAFEF00D);
    do_req(0, 1'b1, 2'd1, 1'b0, 8'h22, 32'hAAAA1234);
    do_req(0, 1'b0, 2'd1, 1'b1, 8'h22, 32'h0);
    chk("half_unsigned", rd_got, 32'h00001234);
    do_req(0, 1'b0, 2'd2, 1'b0, 8'h20, 32'h0);
    chk("half_merge", rd_got, 32'h1234F00D);
    do_req(0, 1'b1, 2'd2, 1'b0, 8'h04, 32'h11223344);
    prev_rd = rd_got;
    do_req(0, 1'b0, 2'd2, 1'b0, 8'h05, 32'h0);
    chk("misaligned_word", rd_got, TRAP ? prev_rd : 32'h11223344);

    // Reset during WAIT of a store aborts it.
    @(negedge clk);
    old30 = mdl[0][12];
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = 2'd2;
    address[0] = 8'h30; write_data[0] = ~old30;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    rd_model[0] = 32'd0;
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_resp", 32'(resp_valid[0]), 32'd0);
      @(negedge clk);
    end
    chk("abort_ready", 32'(req_ready[0]), 32'd1);
    chk("abort_read_data", read_data[0], 32'd0);
    do_req(0, 1'b0, 2'd2, 1'b0, 8'h30, 32'h0);
    chk("abort_word_kept", rd_got, old30);

    // Randomized traffic, sometimes with an idle cycle between requests.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        chk("idle_no_resp", 32'(resp_valid[0]), 32'd0);
      end
      do_req(0, 1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom_range(0, 63)), $urandom);
    end

    // Back-to-back on LATENCY=1 with ReqValid held high throughout.
    @(negedge clk);
    have_prev = 1'b0;
    prev_exp  = 32'd0;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom); sz = 2'($urandom); u = 1'($urandom);
      a = 8'($urandom_range(0, 31)); wd = $urandom;
      req_valid[1] = 1'b1; req_write[1] = w; req_size[1] = sz;
      req_unsigned[1] = u; address[1] = a; write_data[1] = wd;
      chk("b2b_ready", 32'(req_ready[1]), 32'd1);
      chk("b2b_resp", 32'(resp_valid[1]), 32'(have_prev));
      if (have_prev) chk("b2b_read_data", read_data[1], prev_exp);
      @(posedge clk);
      model_apply(1, w, sz, u, a, wd, prev_exp, e);
      have_prev = 1'b1;
      #1;
      req_write[1] = 1'($urandom); address[1] = 8'($urandom); write_data[1] = $urandom;
      @(negedge clk);
      chk("b2b_wait_ready", 32'(req_ready[1]), 32'd0);
      chk("b2b_wait_resp", 32'(resp_valid[1]), 32'd0);
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    chk("b2b_last_resp", 32'(resp_valid[1]), 32'd1);
    chk("b2b_last_data", read_data[1], prev_exp);
    @(negedge clk);
    chk("b2b_idle", 32'(resp_valid[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
